// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler: FSM state encoding and
// the prescaler width helper.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned NREQ_DEF     = 4;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned PRESCALE_DEF = 50000;

    // Bits needed to hold a prescaler value in 0..prescale-1.
    function automatic int unsigned ps_width(input int unsigned prescale);
        return $clog2(prescale);
    endfunction

endpackage

// File: rtl/delay_scheduler_if.sv
// Requester-side bundle of the delay scheduler: level requests and delays in,
// one-hot grant and completion pulses out.
interface delay_scheduler_if #(
    parameter int unsigned NREQ = delay_sched_pkg::NREQ_DEF,
    parameter int unsigned DW   = delay_sched_pkg::DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] delay;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic               tick;

    modport master (output req, output delay, input gnt, input done, input busy, input tick);
    modport slave  (input req, input delay, output gnt, output done, output busy, output tick);
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a tick: counts 0..PRESCALE-1 while enabled, with a
// synchronous clear; wrap_c flags the wrapping cycle, tick is its registered copy.
module tick_prescaler
    import delay_sched_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic wrap_c,
    output logic tick
);
    localparam int unsigned PW = ps_width(PRESCALE);

    logic [PW-1:0] cnt;

    assign wrap_c = en && !clear && (cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap_c;
            if (clear || wrap_c) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + PW'(1);
            end
        end
    end
endmodule

// File: rtl/delay_scheduler.sv
// Shares one prescaled time base and one delay down-counter among NREQ
// requesters, granted round-robin, with a one-cycle done pulse per service.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    delay_scheduler_if.slave  bus
);
    localparam int unsigned IW = $clog2(NREQ);

    state_e          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [DW-1:0]   remaining;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;

    logic            sel_valid_c;
    logic [IW-1:0]   sel_idx_c;
    logic [DW-1:0]   sel_delay_c;
    logic            req_cur_c;
    logic            ps_clear_c;
    logic            ps_en_c;
    logic            wrap_c;
    logic            tick;

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] i);
        return (int'(i) == int'(NREQ) - 1) ? '0 : i + IW'(1);
    endfunction

    // Round-robin pick: first asserted request at or above ptr, wrapping.
    always_comb begin
        int j;
        sel_valid_c = 1'b0;
        sel_idx_c   = '0;
        j           = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= int'(NREQ)) begin
                j = j - int'(NREQ);
            end
            if (bus.req[j]) begin
                sel_valid_c = 1'b1;
                sel_idx_c   = IW'(j);
            end
        end
        sel_delay_c = bus.delay[int'(sel_idx_c)*DW +: DW];
    end

    assign req_cur_c  = bus.req[cur];
    assign ps_clear_c = (state == IDLE);
    // Stop the time base on the aborting cycle so no stray tick follows it.
    assign ps_en_c    = (state == COUNT) && req_cur_c;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ps_clear_c),
        .en     (ps_en_c),
        .wrap_c (wrap_c),
        .tick   (tick)
    );

    // Service FSM with registered grant, done and busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            remaining <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid_c) begin
                        state     <= COUNT;
                        cur       <= sel_idx_c;
                        gnt_q     <= NREQ'(1) << sel_idx_c;
                        busy_q    <= 1'b1;
                        remaining <= (sel_delay_c == '0) ? DW'(1) : sel_delay_c;
                    end
                end
                COUNT: begin
                    if (!req_cur_c) begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        ptr    <= ptr_next(cur);
                    end else if (wrap_c) begin
                        remaining <= remaining - DW'(1);
                        if (remaining == DW'(1)) begin
                            state  <= DONE;
                            gnt_q  <= '0;
                            done_q <= gnt_q;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    ptr    <= ptr_next(cur);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick;
endmodule
